// File: rtl/mul_arb_pkg.sv
// Shared definitions for the two-requester bf16 multiplier arbiter.
//   NUM_REQ       : number of requesters sharing the multiplier
//   bf16_t        : raw 16-bit bf16 word, never decoded
//   tag_t         : {valid, id} carried alongside each in-flight product
//   *_DEF         : default multiplier latency and response FIFO depth
package mul_arb_pkg;

    localparam int NUM_REQ       = 2;
    localparam int MUL_LAT_DEF   = 1;
    localparam int RSP_DEPTH_DEF = 2;

    typedef logic [15:0] bf16_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/mul_arb_if.sv
// Requester-side bus of mul_arb: per-requester operand request handshake
// and per-requester product response handshake.
//   master : requester side (drives req_valid/req_a/req_b/rsp_ready)
//   slave  : arbiter side   (drives req_ready/rsp_valid/rsp_c)
interface mul_arb_if;
    import mul_arb_pkg::*;

    logic  [NUM_REQ-1:0] req_valid;
    logic  [NUM_REQ-1:0] req_ready;
    bf16_t [NUM_REQ-1:0] req_a;
    bf16_t [NUM_REQ-1:0] req_b;
    logic  [NUM_REQ-1:0] rsp_valid;
    logic  [NUM_REQ-1:0] rsp_ready;
    bf16_t [NUM_REQ-1:0] rsp_c;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_c
    );

endinterface

// File: rtl/mul_arb_rsp_fifo.sv
// rsp_fifo: per-requester response FIFO holding multiplier products.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write a product (accepted when not full, or full with pop)
//   pop, dout  : read the head; dout is the current head entry
//   full, empty, count : occupancy status
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written, even when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mul_arb.sv
// mul_arb: round-robin arbiter sharing one external bf16 multiplier between
// two requesters, with credit-based per-requester response FIFOs.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : per-requester request and response handshakes
//   mul_a, mul_b   : operands to the shared multiplier (zero when idle)
//   mul_c          : product, valid MUL_LAT cycles after the operands
module mul_arb
    import mul_arb_pkg::*;
#(
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    mul_arb_if.slave    bus,
    output bf16_t       mul_a,
    output bf16_t       mul_b,
    input  bf16_t       mul_c
);

    localparam int            CW         = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(RSP_DEPTH);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] fifo_full;
    logic [NUM_REQ-1:0] fifo_empty;
    logic               gnt_vld;
    logic               gnt_id;
    logic               last_gnt;
    tag_t               tag_p [MUL_LAT];
    tag_t               tag_exit;

    assign tag_exit      = tag_p[MUL_LAT-1];
    assign bus.req_ready = gnt;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic [CW-1:0] fifo_cnt;
        logic [CW-1:0] infl;
        logic [CW:0]   used;
        bf16_t         fifo_dout;

        // Credit counts FIFO entries plus products still in the multiplier,
        // so every product that exits is guaranteed a FIFO slot.
        assign used     = {1'b0, fifo_cnt} + {1'b0, infl};
        assign elig[i]  = rst_n && bus.req_valid[i] && (used < CREDIT_MAX);
        assign push[i]  = tag_exit.valid && (tag_exit.id == 1'(i));
        assign pop[i]   = !fifo_empty[i] && bus.rsp_ready[i];

        assign bus.rsp_valid[i] = !fifo_empty[i];
        assign bus.rsp_c[i]     = fifo_empty[i] ? '0 : fifo_dout;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                infl <= '0;
            end else begin
                case ({gnt[i], push[i]})
                    2'b10:   infl <= infl + 1'b1;
                    2'b01:   infl <= infl - 1'b1;
                    default: infl <= infl;
                endcase
            end
        end

        rsp_fifo #(
            .DEPTH (RSP_DEPTH),
            .W     (16)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[i]),
            .din   (mul_c),
            .pop   (pop[i]),
            .dout  (fifo_dout),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (fifo_cnt)
        );

        // The credit rule must never let a product arrive at a full FIFO
        // unless the head leaves in the same cycle.
        always_ff @(posedge clk) begin
            if (rst_n && push[i]) begin
                assert (!fifo_full[i] || pop[i]);
            end
        end
    end

    // Grant: single eligible wins; on contention the one not granted last.
    always_comb begin
        gnt_vld = |elig;
        gnt_id  = 1'b0;
        case (elig)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_gnt;
            default: gnt_id = 1'b0;
        endcase
        gnt   = '0;
        mul_a = '0;
        mul_b = '0;
        if (gnt_vld) begin
            gnt[gnt_id] = 1'b1;
            mul_a       = bus.req_a[gnt_id];
            mul_b       = bus.req_b[gnt_id];
        end
    end

    // Reset value 1 makes requester 0 win the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (gnt_vld) begin
            last_gnt <= gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) tag_p[k] <= '0;
        end else begin
            // Stage 0: tag captured on the grant edge, alongside the operands.
            tag_p[0] <= '{valid: gnt_vld, id: gnt_id};
            // Stages 1..MUL_LAT-1: tag tracks the product through the multiplier.
            for (int k = 1; k < MUL_LAT; k++) tag_p[k] <= tag_p[k-1];
        end
    end

endmodule

// File: tb/tb_mul_arb.sv
module tb_mul_arb;
    import mul_arb_pkg::*;

    localparam int MUL_LAT   = 1;
    localparam int RSP_DEPTH = 2;

    typedef struct packed {
        bf16_t c;
        int    t;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    bf16_t mul_a, mul_b, mul_c;
    bf16_t mpipe [MUL_LAT];

    int cmp = 0;
    int bad = 0;
    int cyc = 0;

    mul_arb_if bus ();

    mul_arb #(
        .MUL_LAT   (MUL_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_c (mul_c)
    );

    always #5 clk = ~clk;

    // Truncating bf16 multiply for normal operands.
    function automatic bf16_t bf16_mul(input bf16_t a, input bf16_t b);
        logic        s;
        int          e;
        logic [15:0] p;
        logic [6:0]  m;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'h0 || b[14:0] == 15'h0) return {s, 15'h0};
        p = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            m = p[14:8];
            e = e + 1;
        end else begin
            m = p[13:7];
        end
        if (e <= 0)   return {s, 15'h0};
        if (e >= 255) return {s, 8'hFF, 7'h0};
        return {s, 8'(e), m};
    endfunction

    // External shared multiplier with MUL_LAT cycles latency.
    always @(posedge clk) begin
        mpipe[0] <= bf16_mul(mul_a, mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_c = mpipe[MUL_LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: per-requester queue of accepted products with the
    // cycle they were accepted; credit = depth - outstanding entries.
    exp_t        expq [2][$];
    logic        m_last = 1'b1;
    logic [1:0]  m_el, m_gnt;
    logic        m_gid, m_rv;
    bf16_t       m_a, m_b;
    exp_t        m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            cmp++;
            if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.rsp_c !== 32'h0 ||
                mul_a !== 16'h0 || mul_b !== 16'h0) begin
                bad++;
                $display("FAIL reset_quiet t=%0t: ready=%b rsp_valid=%b rsp_c=%h mul_a=%h mul_b=%h, required all zero",
                         $time, bus.req_ready, bus.rsp_valid, bus.rsp_c, mul_a, mul_b);
            end
            for (int i = 0; i < 2; i++) expq[i].delete();
            m_last = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++)
                m_el[i] = bus.req_valid[i] && (expq[i].size() < RSP_DEPTH);
            m_gid = 1'b0;
            if (m_el == 2'b11)      m_gid = ~m_last;
            else if (m_el == 2'b10) m_gid = 1'b1;
            m_gnt = 2'b00;
            if (m_el != 2'b00) m_gnt[m_gid] = 1'b1;
            cmp++;
            if (bus.req_ready !== m_gnt) begin
                bad++;
                $display("FAIL grant t=%0t: req_ready=%b required %b", $time, bus.req_ready, m_gnt);
            end
            m_a = (m_gnt != 2'b00) ? bus.req_a[m_gid] : 16'h0;
            m_b = (m_gnt != 2'b00) ? bus.req_b[m_gid] : 16'h0;
            cmp++;
            if (mul_a !== m_a || mul_b !== m_b) begin
                bad++;
                $display("FAIL mul_operands t=%0t: mul_a=%h mul_b=%h required %h %h", $time, mul_a, mul_b, m_a, m_b);
            end
            for (int i = 0; i < 2; i++) begin
                m_rv = (expq[i].size() > 0) && (cyc >= expq[i][0].t + MUL_LAT);
                cmp++;
                if (bus.rsp_valid[i] !== m_rv) begin
                    bad++;
                    $display("FAIL rsp_valid%0d t=%0t: got %b required %b", i, $time, bus.rsp_valid[i], m_rv);
                end
                if (m_rv) begin
                    cmp++;
                    if (bus.rsp_c[i] !== expq[i][0].c) begin
                        bad++;
                        $display("FAIL rsp_c%0d t=%0t: got %h required %h", i, $time, bus.rsp_c[i], expq[i][0].c);
                    end
                    if (bus.rsp_ready[i]) void'(expq[i].pop_front());
                end
            end
            if (m_gnt != 2'b00) begin
                m_e.c = bf16_mul(bus.req_a[m_gid], bus.req_b[m_gid]);
                m_e.t = cyc + 1;
                expq[m_gid].push_back(m_e);
                m_last = m_gid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (4 * (MUL_LAT + RSP_DEPTH)) tick();
    endtask

    task automatic test_reset();
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        bus.req_a     = {16'h3F80, 16'h4000};
        bus.req_b     = {16'h4040, 16'h3FC0};
        repeat (3) @(posedge clk);
        #1;
        cmp++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b required 00", bus.req_ready); end
        cmp++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid: got %b required 00", bus.rsp_valid); end
        cmp++; if (bus.rsp_c !== 32'h0) begin bad++; $display("FAIL rst_rsp_c: got %h required 0", bus.rsp_c); end
        cmp++; if (mul_a !== 16'h0) begin bad++; $display("FAIL rst_mul_a: got %h required 0000", mul_a); end
        cmp++; if (mul_b !== 16'h0) begin bad++; $display("FAIL rst_mul_b: got %h required 0000", mul_b); end
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        bus.req_a[0]  = 16'h3FC0;
        bus.req_b[0]  = 16'h4000;
        #1;
        cmp++; if (mul_a !== 16'h3FC0) begin bad++; $display("FAIL single_mul_a: got %h required 3fc0", mul_a); end
        cmp++; if (mul_b !== 16'h4000) begin bad++; $display("FAIL single_mul_b: got %h required 4000", mul_b); end
        cmp++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got %b required 01", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        for (int k = 0; k < MUL_LAT; k++) begin
            #1;
            cmp++; if (bus.rsp_valid[0] !== 1'b0) begin bad++; $display("FAIL single_early: rsp_valid0=%b required 0", bus.rsp_valid[0]); end
            tick();
        end
        #1;
        cmp++; if (bus.rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL single_rsp_valid: got %b required 1", bus.rsp_valid[0]); end
        cmp++; if (bus.rsp_c[0] !== 16'h4040) begin bad++; $display("FAIL single_rsp_c: got %h required 4040", bus.rsp_c[0]); end
        bus.rsp_ready = 2'b11;
        tick();
    endtask

    task automatic test_contention();
        int n = 0;
        do_reset();
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b11;
        bus.req_a     = {16'hC000, 16'h3F80};
        bus.req_b     = {16'h3FC0, 16'h3F00};
        #1;
        cmp++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL contend_first: got %b required 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b10;
        #1;
        cmp++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL contend_second: got %b required 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        while (bus.rsp_valid !== 2'b11 && n < 20) begin
            tick();
            n++;
        end
        cmp++; if (bus.rsp_valid !== 2'b11) begin bad++; $display("FAIL contend_wait: rsp_valid=%b required 11 within 20 cycles", bus.rsp_valid); end
        cmp++; if (bus.rsp_c[0] !== 16'h3F00) begin bad++; $display("FAIL contend_c0: got %h required 3f00", bus.rsp_c[0]); end
        cmp++; if (bus.rsp_c[1] !== 16'hC040) begin bad++; $display("FAIL contend_c1: got %h required c040", bus.rsp_c[1]); end
        bus.rsp_ready = 2'b11;
        tick();
    endtask

    task automatic test_backpressure();
        int g = 0;
        bus.rsp_ready = 2'b01;
        bus.req_valid = 2'b10;
        for (int k = 0; k < 20; k++) begin
            bus.req_a[1] = 16'($urandom);
            bus.req_b[1] = 16'($urandom);
            #1;
            if (bus.req_ready[1]) g++;
            tick();
        end
        cmp++; if (g != RSP_DEPTH) begin bad++; $display("FAIL bp_grants: got %0d required %0d", g, RSP_DEPTH); end
        #1;
        cmp++; if (bus.req_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_blocked: req_ready1=%b required 0", bus.req_ready[1]); end
        tick();
        bus.rsp_ready = 2'b11;
        #1;
        cmp++; if (bus.req_ready[1] !== 1'b0) begin bad++; $display("FAIL bp_same_cycle: req_ready1=%b required 0", bus.req_ready[1]); end
        tick();
        bus.rsp_ready = 2'b01;
        #1;
        cmp++; if (bus.req_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_next_cycle: req_ready1=%b required 1", bus.req_ready[1]); end
        tick();
        bus.req_valid = 2'b00;
    endtask

    task automatic test_full_stream();
        int g = 0;
        int p = 0;
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b10;
        for (int k = 0; k < 30; k++) begin
            bus.req_a[1] = 16'($urandom);
            bus.req_b[1] = 16'($urandom);
            #1;
            if (bus.req_ready[1]) g++;
            if (bus.rsp_valid[1]) p++;
            tick();
        end
        bus.req_valid = 2'b00;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bus.rsp_valid[1]) p++;
            tick();
        end
        cmp++; if (g == 0) begin bad++; $display("FAIL stream_grants: got 0 required nonzero"); end
        cmp++; if (p != g + RSP_DEPTH) begin bad++; $display("FAIL stream_pops: got %0d required %0d", p, g + RSP_DEPTH); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            bus.req_valid = 2'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            bus.req_a     = {16'($urandom), 16'($urandom)};
            bus.req_b     = {16'($urandom), 16'($urandom)};
            tick();
        end
        drain();
        cmp++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL random_drain: rsp_valid=%b required 00", bus.rsp_valid); end
    endtask

    task automatic test_reset_midflight();
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b01;
        bus.req_a[0]  = 16'h4040;
        bus.req_b[0]  = 16'h4000;
        tick();
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        cmp++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL mid_ready: got %b required 00", bus.req_ready); end
        cmp++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin bad++; $display("FAIL mid_mul: got %h %h required 0000 0000", mul_a, mul_b); end
        cmp++; if (bus.rsp_valid !== 2'b00 || bus.rsp_c !== 32'h0) begin bad++; $display("FAIL mid_rsp: valid=%b c=%h required 0", bus.rsp_valid, bus.rsp_c); end
        tick();
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        for (int k = 0; k < 2 * MUL_LAT + 4; k++) begin
            #1;
            cmp++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL mid_discard: rsp_valid=%b required 00", bus.rsp_valid); end
            tick();
        end
    endtask

    task automatic test_idle();
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        for (int k = 0; k < 10; k++) begin
            bus.req_a = {16'($urandom) | 16'h1, 16'($urandom) | 16'h1};
            bus.req_b = {16'($urandom) | 16'h1, 16'($urandom) | 16'h1};
            #1;
            cmp++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin bad++; $display("FAIL idle_mul: got %h %h required 0000 0000", mul_a, mul_b); end
            tick();
        end
        bus.req_valid = 2'b11;
        #1;
        cmp++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL idle_last_grant: req_ready=%b required 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        drain();
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_single();
        drain();
        test_contention();
        drain();
        test_backpressure();
        test_full_stream();
        drain();
        test_random();
        test_reset_midflight();
        test_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mul_arb.md
MUL_ARB -- requirements
Module: mul_arb

Interface
REQ-001 Parameter MUL_LAT, default 1, meaning: shared bf16 multiplier latency in cycles, operands to product; legal range 1..4.
REQ-002 Parameter RSP_DEPTH, default 2, meaning: per-requester response FIFO depth; legal range 2..8.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester operand request valid.
REQ-006 req_ready  output  2  per-requester request accepted this cycle.
REQ-007 req_a  input  2x16  per-requester bf16 operand a.
REQ-008 req_b  input  2x16  per-requester bf16 operand b.
REQ-009 rsp_valid  output  2  per-requester product available.
REQ-010 rsp_ready  input  2  per-requester product consumed.
REQ-011 rsp_c  output  2x16  per-requester bf16 product.
REQ-012 mul_a  output  16  operand a to shared multiplier.
REQ-013 mul_b  output  16  operand b to shared multiplier.
REQ-014 mul_c  input  16  product from shared multiplier, valid MUL_LAT cycles after operands.

Function
REQ-015 Request handshake: transfer when req_valid[i] and req_ready[i] are both high on a clk edge; at most one req_ready bit high per cycle.
REQ-016 Eligibility: requester i eligible when req_valid[i]=1 and credit[i]>0; credit[i] = RSP_DEPTH - (FIFO occupancy[i] + in-flight count[i]).
REQ-017 Arbitration: round-robin; only one eligible -> grant it; both eligible -> grant the requester not granted most recently.
REQ-018 last_grant pointer updates only on a grant; idle cycles leave it unchanged.
REQ-019 req_ready is combinational from eligibility and last_grant; no dependence on req_a/req_b.
REQ-020 On grant: mul_a/mul_b = granted requester's req_a/req_b, combinational same cycle; no grant: mul_a=mul_b=16'h0000.
REQ-021 Tag pipeline: MUL_LAT-stage shift register of {valid, id}; stage 0 loaded on grant edge.
REQ-022 Tag pipeline exit valid: mul_c pushed into response FIFO[id] that cycle.
REQ-023 Products are never dropped; credit rule guarantees FIFO space at push.
REQ-024 Responses per requester return in request order; no cross-requester ordering guarantee.
REQ-025 rsp_valid[i] = FIFO[i] non-empty; rsp_c[i] = FIFO[i] head; pop on rsp_valid[i] and rsp_ready[i].
REQ-026 Simultaneous push and pop on one FIFO: both occur, occupancy unchanged, also when full.
REQ-027 Credit freed by a pop is usable for a grant the following cycle, not the same cycle.
REQ-028 Throughput: one grant per cycle sustained while the granted requester has credit and rsp_ready held high.
REQ-029 No sign, NaN or subnormal inspection; operands and products pass through bit-exact.

Reset
REQ-030 rst_n low: req_ready=0, rsp_valid=0, rsp_c=0, mul_a=mul_b=0 immediately, regardless of clk.
REQ-031 Reset clears FIFOs, in-flight counters and tag pipeline; mid-operation products are discarded, and mul_c arriving after reset is ignored.
REQ-032 last_grant resets to requester 1, so requester 0 wins the first contended cycle.
REQ-033 First grant possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 Package mul_arb_pkg holds: NUM_REQ=2, bf16_t typedef (16-bit), tag_t struct {valid, id}, default MUL_LAT/RSP_DEPTH constants.
REQ-035 One sub-module rsp_fifo (depth RSP_DEPTH, width 16, push/pop/full/empty/count), instantiated once per requester.
REQ-036 Shared multiplier instantiated outside mul_arb; only mul_a/mul_b/mul_c cross the boundary.

Verification
REQ-037 Single request: req0 a=3FC0, b=4000 -> mul_a=3FC0, mul_b=4000 same cycle; rsp_valid[0] MUL_LAT+1 edges later with rsp_c=4040.
REQ-038 Contention after reset: both valid (req0 3F80x3F00, req1 C000x3FC0) -> req0 granted first, req1 next cycle; rsp_c[0]=3F00, rsp_c[1]=C040.
REQ-039 Backpressure: rsp_ready[1]=0, req1 valid continuously -> exactly RSP_DEPTH grants to req1, then req_ready[1]=0 until a pop.
REQ-040 Full FIFO with simultaneous push and pop: occupancy stays RSP_DEPTH, order preserved, no product lost.
REQ-041 Reset mid-flight: rst_n low one cycle after grant -> all outputs 0 immediately; no rsp_valid for the discarded request after release.
REQ-042 Idle: req_valid=0 for 10 cycles -> mul_a=mul_b=0000, last_grant unchanged.
